// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-access, memory-macro and stall signals of the memory port arbiter.
// slave is the arbiter; master is its surroundings (IF/MEM stages and the memory macro).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and MEM-stage data access.
// One transaction at a time: IDLE (grant) -> ISSUE -> WAIT (MEM_LAT) -> ACK.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  owner_t            last_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant_d;
  logic              grant_if;
  logic              data_done;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Data wins a conflict unless it also won the previous grant.
  always_comb begin
    grant_d  = bus.d_req & (~bus.if_req | (last_grant == OWN_IF));
    grant_if = bus.if_req & ~grant_d;
  end

  assign data_done = (state == WAIT) && (wait_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d | grant_if) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (data_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en = 1'b0;
    bus.if_ack = 1'b0;
    bus.d_ack  = 1'b0;
    case (state)
      ISSUE:   bus.mem_en = 1'b1;
      ACK: begin
        bus.if_ack = (owner == OWN_IF);
        bus.d_ack  = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= CNT_W'(MEM_LAT);
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end
  end

  // Request fields are sampled only at the grant edge and then held until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_IF;
      last_grant  <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (state == IDLE && (grant_d | grant_if)) begin
        owner       <= grant_d ? OWN_D : OWN_IF;
        last_grant  <= grant_d ? OWN_D : OWN_IF;
        mem_we_q    <= grant_d & bus.d_we;
        mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
        mem_wdata_q <= bus.d_wdata;
      end
      if (data_done && !mem_we_q) begin
        if (owner == OWN_D) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.stall_if  = bus.if_req & ~bus.if_ack;
  assign bus.stall_mem = bus.d_req & ~bus.d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model; a second instance covers MEM_LAT=1.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int LAT1   = 1;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return (i == 8'h40) ? 32'h0050_0093 : {i, ~i, 8'h3C, i ^ 8'h5A};
  endfunction

  function automatic logic [31:0] rand_addr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  // Memory macro for the MEM_LAT=2 instance; garbage on mem_rdata outside valid slots.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : $urandom();
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  // Read-only memory for the MEM_LAT=1 instance.
  logic [31:0] rd1;
  always @(posedge clk) begin
    rd1 <= (bus1.mem_en && !bus1.mem_we) ? init_word(bus1.mem_addr[9:2]) : $urandom();
  end
  assign bus1.mem_rdata = rd1;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction described by its grant cycle.
  int          cyc;
  int          free_at;
  int          t_grant;
  bit          active;
  bit          lastg_d;
  bit          own_d;
  bit          x_we;
  logic [31:0] x_addr;
  logic [31:0] x_wdata;
  logic [31:0] x_rdata;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] shadow [256];
  bit          prev_if_ack;
  bit          prev_d_ack;

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    active       = 1'b0;
    lastg_d      = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    free_at      = cyc + 1;
    prev_if_ack  = 1'b0;
    prev_d_ack   = 1'b0;
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cycle_end();
    bit g_d;
    bit e_en;
    bit e_ifa;
    bit e_da;
    int k;
    #1;
    if (!rst && cyc >= free_at && (bus.if_req || bus.d_req)) begin
      g_d     = bus.d_req && (!bus.if_req || !lastg_d);
      lastg_d = g_d;
      own_d   = g_d;
      t_grant = cyc;
      active  = 1'b1;
      free_at = cyc + 3 + LAT;
      x_addr  = g_d ? bus.d_addr : bus.if_addr;
      x_we    = g_d && bus.d_we;
      x_wdata = bus.d_wdata;
      x_rdata = shadow[x_addr[9:2]];
      if (x_we) shadow[x_addr[9:2]] = x_wdata;
    end
    k     = cyc - t_grant;
    e_en  = active && (k == 1);
    e_ifa = active && !own_d && (k == 2 + LAT);
    e_da  = active && own_d && (k == 2 + LAT);
    if (active && k == 2 + LAT && !x_we) begin
      if (own_d) exp_d_rdata = x_rdata;
      else       exp_if_rdata = x_rdata;
    end
    chk1("mem_en", bus.mem_en, e_en);
    chk1("if_ack", bus.if_ack, e_ifa);
    chk1("d_ack", bus.d_ack, e_da);
    chk1("stall_if", bus.stall_if, bus.if_req && !e_ifa);
    chk1("stall_mem", bus.stall_mem, bus.d_req && !e_da);
    chk32("if_rdata", bus.if_rdata, exp_if_rdata);
    chk32("d_rdata", bus.d_rdata, exp_d_rdata);
    if (active && k >= 1 && k <= 2 + LAT) begin
      chk32("mem_addr", bus.mem_addr, x_addr);
      chk1("mem_we", bus.mem_we, x_we);
      if (x_we) chk32("mem_wdata", bus.mem_wdata, x_wdata);
    end
    prev_if_ack = e_ifa;
    prev_d_ack  = e_da;
    if (rst) model_reset();
  endtask

  task automatic drive_random();
    int r;
    if (!bus.if_req) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.if_req  = 1'b1;
        bus.if_addr = rand_addr();
      end
    end else if (prev_if_ack) begin
      if ($urandom_range(0, 1) == 1) bus.if_req = 1'b0;
      else                           bus.if_addr = rand_addr();
    end else begin
      r = int'($urandom_range(0, 15));
      if (r == 0)     bus.if_req = 1'b0;
      else if (r < 3) bus.if_addr = rand_addr();
    end
    if (!bus.d_req) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom();
      end
    end else if (prev_d_ack) begin
      if ($urandom_range(0, 1) == 1) bus.d_req = 1'b0;
      else begin
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom();
      end
    end else begin
      r = int'($urandom_range(0, 15));
      if (r == 0) bus.d_req = 1'b0;
      else if (r < 3) begin
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = rand_addr();
        bus.d_wdata = $urandom();
      end
    end
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    mem_init     = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus1.if_req  = 1'b0;
    bus1.if_addr = '0;
    bus1.d_req   = 1'b0;
    bus1.d_we    = 1'b0;
    bus1.d_addr  = '0;
    bus1.d_wdata = '0;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
    cyc     = -1;
    t_grant = 0;
    own_d   = 1'b0;
    x_we    = 1'b0;
    x_addr  = '0;
    x_wdata = '0;
    x_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset state
    cycle_begin();
    rst = 1'b0;
    mem_init = 1'b0;
    cycle_end();
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);

    // Single fetch
    for (int c = 0; c <= 5; c++) begin
      cycle_begin();
      bus.if_req  = (c <= 4);
      bus.if_addr = 32'h100;
      cycle_end();
      if (c == 1) chk32("fetch_addr", bus.mem_addr, 32'h100);
      if (c == 1) chk1("fetch_en", bus.mem_en, 1'b1);
      if (c == 4) chk1("fetch_ack", bus.if_ack, 1'b1);
      if (c == 4) chk32("fetch_data", bus.if_rdata, 32'h0050_0093);
    end

    // Store
    for (int c = 0; c <= 5; c++) begin
      cycle_begin();
      bus.d_req   = (c <= 4);
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h200;
      bus.d_wdata = 32'hDEAD_BEEF;
      cycle_end();
      if (c == 1) chk1("store_we", bus.mem_we, 1'b1);
      if (c == 1) chk32("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      if (c == 4) chk1("store_ack", bus.d_ack, 1'b1);
      if (c == 4) chk32("store_rdata", bus.d_rdata, 32'h0);
    end

    // Contention from reset: D, IF, D, IF
    cycle_begin();
    rst = 1'b1;
    idle_inputs();
    cycle_end();
    for (int c = 0; c <= 19; c++) begin
      cycle_begin();
      rst         = 1'b0;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h100;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h40;
      cycle_end();
      if (c == 4)  chk1("cont_d_ack4", bus.d_ack, 1'b1);
      if (c == 9)  chk1("cont_if_ack9", bus.if_ack, 1'b1);
      if (c == 14) chk1("cont_d_ack14", bus.d_ack, 1'b1);
      if (c == 19) chk1("cont_if_ack19", bus.if_ack, 1'b1);
    end

    // Address change after grant is ignored
    for (int c = 0; c <= 5; c++) begin
      cycle_begin();
      bus.if_req = 1'b0;
      bus.d_req  = (c <= 4);
      bus.d_we   = 1'b0;
      bus.d_addr = (c == 0) ? 32'h44 : 32'h80;
      cycle_end();
      if (c == 3) chk32("hold_addr_wait", bus.mem_addr, 32'h44);
      if (c == 4) chk32("hold_addr_ack", bus.mem_addr, 32'h44);
      if (c == 4) chk32("hold_rdata", bus.d_rdata, init_word(8'h11));
    end

    // Reset while waiting for load data, then a fresh load
    for (int c = 0; c <= 9; c++) begin
      cycle_begin();
      rst        = (c == 2);
      bus.d_req  = (c <= 2) || (c >= 4 && c <= 8);
      bus.d_we   = 1'b0;
      bus.d_addr = (c <= 2) ? 32'h48 : 32'h4C;
      cycle_end();
      if (c == 3) chk1("rstw_no_ack", bus.d_ack, 1'b0);
      if (c == 3) chk32("rstw_rdata", bus.d_rdata, 32'h0);
      if (c == 3) chk1("rstw_no_en", bus.mem_en, 1'b0);
      if (c == 8) chk1("rstw_fresh_ack", bus.d_ack, 1'b1);
      if (c == 8) chk32("rstw_fresh_data", bus.d_rdata, init_word(8'h13));
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle_begin();
      drive_random();
      cycle_end();
    end
    for (int n = 0; n < 8; n++) begin
      cycle_begin();
      idle_inputs();
      cycle_end();
    end

    // MEM_LAT=1 instance: single load, then idle
    for (int c = 0; c <= 5; c++) begin
      cycle_begin();
      bus1.d_req  = (c <= 2);
      bus1.d_we   = 1'b0;
      bus1.d_addr = 32'h48;
      cycle_end();
      chk1("lat1_mem_en", bus1.mem_en, c == 1);
      chk1("lat1_d_ack", bus1.d_ack, c == 3);
      chk1("lat1_if_ack", bus1.if_ack, 1'b0);
      if (c == 3) chk32("lat1_rdata", bus1.d_rdata, init_word(8'h12));
    end
    for (int c = 0; c < 10; c++) begin
      cycle_begin();
      bus1.d_req  = 1'b0;
      bus1.if_req = 1'b0;
      cycle_end();
      chk1("lat1_idle_en", bus1.mem_en, 1'b0);
      chk1("lat1_idle_ack", bus1.d_ack | bus1.if_ack, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
